// File: rtl/stream_arb2.sv
// stream_arb2: two-input stream arbiter feeding a registered output stage (round robin when STREAM_ARB2_RR_EN is defined, else fixed A priority).
// Latency: one cycle from input handshake to y_valid/y_data.
// Backpressure: y_ready gates both input readies combinationally, so a stalled output holds and restarts with no bubble.
module stream_arb2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] y_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_src
);

    logic [WIDTH-1:0] y_data_q,  y_data_d;
    logic             y_valid_q, y_valid_d;
    logic             y_src_q,   y_src_d;
    logic             load;
    logic             sel_c;

`ifdef STREAM_ARB2_RR_EN
    logic last_src_q, last_src_d;

    always_comb begin
        sel_c = last_src_q;
        unique case ({a_valid, b_valid})
            2'b11:   sel_c = !last_src_q;
            2'b10:   sel_c = 1'b0;
            2'b01:   sel_c = 1'b1;
            default: sel_c = last_src_q;
        endcase
    end
`else
    always_comb begin
        sel_c = !a_valid && b_valid;
    end
`endif

    // rst_n gates the readies so no producer sees a handshake while the register is held in reset.
    always_comb begin
        load    = !y_valid_q || y_ready;
        a_ready = rst_n && load && a_valid && !sel_c;
        b_ready = rst_n && load && b_valid &&  sel_c;
    end

    always_comb begin
        y_data_d  = y_data_q;
        y_valid_d = y_valid_q;
        y_src_d   = y_src_q;
`ifdef STREAM_ARB2_RR_EN
        last_src_d = last_src_q;
`endif
        if (load) begin
            if (a_ready) begin
                y_data_d  = a_data;
                y_valid_d = 1'b1;
                y_src_d   = 1'b0;
`ifdef STREAM_ARB2_RR_EN
                last_src_d = 1'b0;
`endif
            end else if (b_ready) begin
                y_data_d  = b_data;
                y_valid_d = 1'b1;
                y_src_d   = 1'b1;
`ifdef STREAM_ARB2_RR_EN
                last_src_d = 1'b1;
`endif
            end else begin
                y_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
            y_src_q   <= 1'b0;
        end else begin
            y_data_q  <= y_data_d;
            y_valid_q <= y_valid_d;
            y_src_q   <= y_src_d;
        end
    end

`ifdef STREAM_ARB2_RR_EN
    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src_q <= 1'b1;
        end else begin
            last_src_q <= last_src_d;
        end
    end
`endif

    assign sel     = sel_c;
    assign y_data  = y_data_q;
    assign y_valid = y_valid_q;
    assign y_src   = y_src_q;

endmodule
